// File: rtl/q16_mac_window.sv
// q16_mac_window: int16 x int16 MAC over N_TAPS-sample windows, round, shift and saturate to int16
module q16_mac_window #(
  parameter int N_TAPS     = 9,
  parameter int FRAC_SHIFT = 8,
  parameter int ACC_W      = 40
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               valid_in,
  input  logic signed [15:0] data_in,
  input  logic signed [15:0] weight_in,
  input  logic               clear,
  output logic signed [15:0] data_out,
  output logic               valid_out,
  output logic               sat_out
);
  localparam int CW = N_TAPS > 1 ? $clog2(N_TAPS) : 1;
  localparam logic [CW-1:0] LAST_TAP = CW'(N_TAPS - 1);
  localparam logic signed [ACC_W:0] HALF =
    FRAC_SHIFT == 0 ? '0 : (ACC_W + 1)'(1) << (FRAC_SHIFT > 0 ? FRAC_SHIFT - 1 : 0);
  localparam logic signed [ACC_W:0] MAX16 = (ACC_W + 1)'(32767);
  localparam logic signed [ACC_W:0] MIN16 = -(ACC_W + 1)'(32768);
  logic [CW-1:0] cnt_q, cnt_d, base;
  logic signed [31:0] prod_q, prod_d;
  logic prod_v_q, prod_v_d, last_q, last_d;
  logic signed [ACC_W-1:0] acc_q, acc_d, sum_q, sum_d, psum;
  logic sum_v_q, sum_v_d;
  logic signed [ACC_W:0] rnd, shifted;
  logic hi, lo;
  logic signed [15:0] data_out_q, data_out_d;
  logic valid_out_q, valid_out_d, sat_out_q, sat_out_d;
  // stage 1: multiply and tag the window's last tap; clear restarts counting at this sample
  always_comb begin
    base     = clear ? '0 : cnt_q;
    prod_v_d = valid_in;
    prod_d   = valid_in ? 32'(data_in * weight_in) : prod_q;
    last_d   = valid_in ? base == LAST_TAP : last_q;
    cnt_d    = valid_in ? (base == LAST_TAP ? '0 : base + 1'b1) : base;
  end
  // stage 2: accumulate; a last tap hands the full sum on and zeroes acc for the next window
  always_comb begin
    psum    = acc_q + {{(ACC_W - 32){prod_q[31]}}, prod_q};
    sum_v_d = prod_v_q && last_q && !clear;
    sum_d   = sum_v_d ? psum : sum_q;
    acc_d   = (clear || (prod_v_q && last_q)) ? '0 : prod_v_q ? psum : acc_q;
  end
  // stage 3: round half-up, arithmetic shift, clip to int16 and launch the pulse
  always_comb begin
    rnd         = {sum_q[ACC_W-1], sum_q} + HALF;
    shifted     = rnd >>> FRAC_SHIFT;
    hi          = shifted > MAX16;
    lo          = shifted < MIN16;
    valid_out_d = sum_v_q;
    data_out_d  = sum_v_q ? (hi ? 16'sh7fff : lo ? -16'sh8000 : shifted[15:0]) : data_out_q;
    sat_out_d   = sum_v_q ? hi || lo : sat_out_q;
  end
  // pipeline registers; reset discards any partial window and in-flight result
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q       <= '0;
      prod_q      <= '0;
      prod_v_q    <= 1'b0;
      last_q      <= 1'b0;
      acc_q       <= '0;
      sum_q       <= '0;
      sum_v_q     <= 1'b0;
      data_out_q  <= '0;
      valid_out_q <= 1'b0;
      sat_out_q   <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      prod_q      <= prod_d;
      prod_v_q    <= prod_v_d;
      last_q      <= last_d;
      acc_q       <= acc_d;
      sum_q       <= sum_d;
      sum_v_q     <= sum_v_d;
      data_out_q  <= data_out_d;
      valid_out_q <= valid_out_d;
      sat_out_q   <= sat_out_d;
    end
  end
  assign data_out  = data_out_q;
  assign valid_out = valid_out_q;
  assign sat_out   = sat_out_q;
endmodule

// File: tb/tb_q16_mac_window.sv
// tb_q16_mac_window: randomized scoreboard bench for q16_mac_window against a window-sum model
module tb_q16_mac_window;
  localparam int N = 9;
  logic clk = 0, rst = 1, valid_in = 0, clear = 0;
  logic signed [15:0] data_in = 0, weight_in = 0;
  logic signed [15:0] data_out;
  logic valid_out, sat_out;
  int cyc = 0, tests = 0, fails = 0;
  typedef struct { longint d; bit s; int c; } exp_t;
  exp_t sb[$];
  int tap = 0;
  longint wsum = 0;
  bit prev_last = 0;

  q16_mac_window dut (.clk(clk), .rst(rst), .valid_in(valid_in), .data_in(data_in),
    .weight_in(weight_in), .clear(clear), .data_out(data_out), .valid_out(valid_out),
    .sat_out(sat_out));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input longint act, input longint expv);
    tests++;
    if (act !== expv) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  function automatic exp_t model_result(input longint s, input int c);
    longint t, q;
    exp_t e;
    t = s + 128;
    q = t >= 0 ? t / 256 : -((-t + 255) / 256);
    e.s = q > 32767 || q < -32768;
    e.d = q > 32767 ? 32767 : q < -32768 ? -32768 : q;
    e.c = c;
    return e;
  endfunction

  // one clock of stimulus, driven on the falling edge, with the model advanced for that edge
  task automatic step(input bit v, input int d, input int w, input bit c);
    valid_in = v; data_in = 16'(d); weight_in = 16'(w); clear = c;
    if (c) begin
      if (prev_last) void'(sb.pop_back());
      tap = 0; wsum = 0;
    end
    prev_last = 0;
    if (v) begin
      wsum += longint'(signed'(16'(d))) * longint'(signed'(16'(w)));
      tap++;
      if (tap == N) begin
        sb.push_back(model_result(wsum, cyc + 3));
        tap = 0; wsum = 0; prev_last = 1;
      end
    end
    @(posedge clk);
    @(negedge clk);
    valid_in = 0; clear = 0;
  endtask

  task automatic do_reset();
    rst = 1;
    @(posedge clk);
    sb.delete();
    tap = 0; wsum = 0; prev_last = 0;
    @(negedge clk);
    @(negedge clk);
    rst = 0;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_data"}, data_out, 0);
    chk({tag, "_valid"}, valid_out, 0);
    chk({tag, "_sat"}, sat_out, 0);
  endtask

  task automatic window(input int d, input int w, input int maxgap);
    for (int i = 0; i < N; i++) begin
      step(1, d, w, 0);
      for (int g = $urandom_range(0, maxgap); g > 0; g--) step(0, 0, 0, 0);
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 8 && sb.size() > 0; i++) step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    if (sb.size() != 0) begin
      chk("drain_pending", sb.size(), 0);
      sb.delete();
    end
  endtask

  task automatic single(input int d, input int w);
    step(1, d, w, 0);
    for (int i = 1; i < N; i++) step(1, 0, 0, 0);
    drain();
  endtask

  // monitor: pops the scoreboard whenever the DUT pulses, flags missed or unexpected pulses
  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].c < cyc) begin
      chk("missed_pulse_cycle", cyc, sb[0].c);
      void'(sb.pop_front());
    end
    if (valid_out && !rst) begin
      if (sb.size() == 0) chk("unexpected_pulse", 1, 0);
      else begin
        exp_t e;
        e = sb.pop_front();
        chk("pulse_cycle", cyc, e.c);
        chk("data_out", data_out, e.d);
        chk("sat_out", sat_out, e.s);
      end
    end
  end

  initial begin
    @(negedge clk);
    do_reset();
    chk_zero("reset");
    window(256, 256, 0); drain();
    chk("t1_hold_data", data_out, 2304);
    chk("t1_hold_sat", sat_out, 0);
    window(32767, 32767, 0); drain();
    window(-32768, 32767, 0); drain();
    single(128, 1);
    single(127, 1);
    single(-128, 1);
    single(-129, 1);
    window(256, 256, 3); drain();
    window(256, 256, 0);
    window(256, -256, 0);
    drain();
    for (int i = 0; i < 4; i++) step(1, 1000, 1000, 0);
    step(0, 0, 0, 1);
    window(256, 256, 0); drain();
    for (int i = 0; i < 4; i++) step(1, 500, 500, 0);
    step(1, 256, 256, 1);
    for (int i = 1; i < N; i++) step(1, 256, 256, 0);
    drain();
    for (int i = 0; i < 5; i++) step(1, 1000, 1000, 0);
    do_reset();
    for (int i = 0; i < 4; i++) begin
      chk_zero("t6_rst");
      step(0, 0, 0, 0);
    end
    window(256, 256, 0); drain();
    for (int i = 0; i < 400; i++) begin
      int m;
      m = $urandom_range(0, 2);
      step($urandom_range(0, 3) != 0,
           m == 0 ? int'($urandom_range(0, 65535)) - 32768 : int'($urandom_range(0, 511)) - 256,
           m == 2 ? int'($urandom_range(0, 65535)) - 32768 : int'($urandom_range(0, 511)) - 256,
           $urandom_range(0, 40) == 0);
    end
    drain();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation exceeded time limit at cycle %0d", cyc);
    $fatal(1, "timeout");
  end
endmodule
